// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared definitions for the arbitrated multiplexer.
//   MODE_FIXED / MODE_RR : arbitration mode selectors
//   out_state_e          : output register occupancy (EMPTY / FULL)
//   idx_width()          : index width for N items, never below 1 bit
package rr_mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Bits needed to index n items; a single item still gets a 1-bit index.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter.sv
// rr_arbiter: combinational grant logic.
//   req     in  NCH   request vector
//   ptr     in  SELW  round-robin start position (ignored for fixed priority)
//   gnt_oh  out NCH   one-hot grant, zero when nothing requests
//   gnt_idx out SELW  index of the granted request
//   any     out 1     at least one request is present
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int MODE = MODE_RR,
  parameter int SELW = idx_width(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  gnt_oh,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  logic [NCH-1:0] w_mask;
  logic [NCH-1:0] w_req_hi;

  // Index of the lowest set bit; zero when the vector is empty.
  function automatic logic [SELW-1:0] lowest_idx(input logic [NCH-1:0] v);
    logic [SELW-1:0] idx;
    idx = {SELW{1'b0}};
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = SELW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Round-robin splits requests into those at/above ptr and the rest; the
  // upper group wins, otherwise the scan wraps to the lowest request overall.
  always_comb begin
    w_mask   = {NCH{1'b1}} << ptr;
    w_req_hi = req & w_mask;
    any      = |req;
    if ((MODE == MODE_RR) && (|w_req_hi)) begin
      gnt_idx = lowest_idx(w_req_hi);
    end else begin
      gnt_idx = lowest_idx(req);
    end
    if (any) begin
      gnt_oh = {{(NCH-1){1'b0}}, 1'b1} << gnt_idx;
    end else begin
      gnt_oh = {NCH{1'b0}};
    end
  end

endmodule

// File: rtl/rr_mux.sv
// rr_mux: N-channel valid/ready multiplexer with arbitration and a one-entry
// registered output stage.
//   clk       in  1          clock, rising edge
//   rst_n     in  1          asynchronous active-low reset
//   in_data   in  NCH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid  in  NCH        channel i holds a word
//   in_ready  out NCH        channel i accepted this cycle (one-hot or zero)
//   out_data  out WIDTH      registered word
//   out_sel   out SELW       channel that produced out_data
//   out_valid out 1          output register is full
//   out_ready in  1          consumer takes the word this cycle
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 4,
  parameter int MODE  = MODE_RR,
  parameter int SELW  = idx_width(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  out_state_e       r_state;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_sel;
  logic [SELW-1:0]  r_ptr;

  out_state_e       w_state_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic [SELW-1:0]  w_sel_nxt;
  logic [SELW-1:0]  w_ptr_nxt;

  logic [NCH-1:0]   w_gnt_oh;
  logic [SELW-1:0]  w_gnt_idx;
  logic             w_any;
  logic             w_can_load;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_data;

  rr_arbiter #(
    .NCH  (NCH),
    .MODE (MODE),
    .SELW (SELW)
  ) u_arb (
    .req     (in_valid),
    .ptr     (r_ptr),
    .gnt_oh  (w_gnt_oh),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign w_can_load = (r_state == ST_EMPTY) || out_ready;
  assign w_accept   = w_any && w_can_load;
  assign w_sel_data = in_data[int'(w_gnt_idx) * WIDTH +: WIDTH];

  // rst_n gates in_ready so no producer sees a handshake while reset holds.
  assign in_ready = (w_can_load && rst_n) ? w_gnt_oh : {NCH{1'b0}};

  // Next-state for the output register and priority pointer; an accept takes
  // precedence over a plain drain so drain+accept keeps the register full.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_out_data;
    w_sel_nxt   = r_out_sel;
    w_ptr_nxt   = r_ptr;
    if (w_accept) begin
      w_state_nxt = ST_FULL;
      w_data_nxt  = w_sel_data;
      w_sel_nxt   = w_gnt_idx;
      if (MODE == MODE_RR) begin
        if (w_gnt_idx == SELW'(NCH - 1)) begin
          w_ptr_nxt = {SELW{1'b0}};
        end else begin
          w_ptr_nxt = w_gnt_idx + SELW'(1);
        end
      end else begin
        w_ptr_nxt = {SELW{1'b0}};
      end
    end else if ((r_state == ST_FULL) && out_ready) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, data, source index and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_out_data <= {WIDTH{1'b0}};
      r_out_sel  <= {SELW{1'b0}};
      r_ptr      <= {SELW{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_out_data <= w_data_nxt;
      r_out_sel  <= w_sel_nxt;
      r_ptr      <= w_ptr_nxt;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_mux.sv
// tb_rr_mux: drives one round-robin and one fixed-priority rr_mux with the
// same stimulus and compares both against a behavioural model.
module tb_rr_mux;

  localparam int NCH   = 4;
  localparam int WIDTH = 4;
  localparam int SELW  = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic                 out_ready;

  logic [NCH-1:0]   rr_in_ready, fx_in_ready;
  logic [WIDTH-1:0] rr_out_data, fx_out_data;
  logic [SELW-1:0]  rr_out_sel, fx_out_sel;
  logic             rr_out_valid, fx_out_valid;

  rr_mux #(.NCH(NCH), .WIDTH(WIDTH), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rr_in_ready), .out_data(rr_out_data), .out_sel(rr_out_sel),
    .out_valid(rr_out_valid), .out_ready(out_ready)
  );

  rr_mux #(.NCH(NCH), .WIDTH(WIDTH), .MODE(0)) u_fx (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(fx_in_ready), .out_data(fx_out_data), .out_sel(fx_out_sel),
    .out_valid(fx_out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: [0] = round-robin, [1] = fixed priority.
  int m_valid [2];
  int m_data  [2];
  int m_sel   [2];
  int m_ptr   [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int word_of(input int ch);
    logic [NCH*WIDTH-1:0] d;
    d = in_data;
    return int'(d[ch*WIDTH +: WIDTH]);
  endfunction

  // First valid channel scanning upward from p with wrap-around; -1 if none.
  function automatic int pick(input int p);
    for (int k = 0; k < NCH; k++) begin
      if (in_valid[(p + k) % NCH]) return (p + k) % NCH;
    end
    return -1;
  endfunction

  function automatic int exp_ready(input int m);
    int g;
    g = pick(m_ptr[m]);
    if (rst_n !== 1'b1) return 0;
    if (g < 0) return 0;
    if (m_valid[m] != 0 && out_ready !== 1'b1) return 0;
    return 1 << g;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 0; m_data[m] = 0; m_sel[m] = 0; m_ptr[m] = 0;
    end
  endtask

  task automatic model_edge();
    int g;
    for (int m = 0; m < 2; m++) begin
      g = pick(m_ptr[m]);
      if (g >= 0 && (m_valid[m] == 0 || out_ready === 1'b1)) begin
        m_valid[m] = 1;
        m_data[m]  = word_of(g);
        m_sel[m]   = g;
        if (m == 0) m_ptr[m] = (g + 1) % NCH;
      end else if (m_valid[m] != 0 && out_ready === 1'b1) begin
        m_valid[m] = 0;
      end
    end
  endtask

  task automatic check_ready(input string tag);
    check_eq({tag, ".rr_in_ready"}, 32'(rr_in_ready), 32'(exp_ready(0)));
    check_eq({tag, ".fx_in_ready"}, 32'(fx_in_ready), 32'(exp_ready(1)));
  endtask

  task automatic check_out(input string tag);
    check_eq({tag, ".rr_valid"}, 32'(rr_out_valid), 32'(m_valid[0]));
    check_eq({tag, ".rr_data"},  32'(rr_out_data),  32'(m_data[0]));
    check_eq({tag, ".rr_sel"},   32'(rr_out_sel),   32'(m_sel[0]));
    check_eq({tag, ".fx_valid"}, 32'(fx_out_valid), 32'(m_valid[1]));
    check_eq({tag, ".fx_data"},  32'(fx_out_data),  32'(m_data[1]));
    check_eq({tag, ".fx_sel"},   32'(fx_out_sel),   32'(m_sel[1]));
  endtask

  // Called 1 time unit after a rising edge with inputs already set.
  task automatic step(input string tag);
    #3;
    check_ready(tag);
    @(posedge clk);
    model_edge();
    #1;
    check_out(tag);
  endtask

  initial begin
    logic [3:0] exp_words [4];
    exp_words[0] = 4'h3; exp_words[1] = 4'h5; exp_words[2] = 4'h9; exp_words[3] = 4'hC;

    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_data   = {4'hC, 4'h9, 4'h5, 4'h3};
    out_ready = 1'b1;
    model_reset();

    // Reset held with every channel requesting.
    @(posedge clk);
    @(posedge clk);
    #1;
    check_ready("reset");
    check_out("reset");
    check_eq("reset.rr_valid_const", 32'(rr_out_valid), 32'd0);
    check_eq("reset.rr_ready_const", 32'(rr_in_ready), 32'd0);
    rst_n = 1'b1;

    // All channels valid, consumer always ready: RR rotates, fixed stays on 0.
    for (int i = 0; i < 8; i++) begin
      step("rr_seq");
      check_eq("rr_seq.sel_const",  32'(rr_out_sel),  32'(i % 4));
      check_eq("rr_seq.data_const", 32'(rr_out_data), 32'(exp_words[i % 4]));
      check_eq("fx_seq.data_const", 32'(fx_out_data), 32'h3);
    end

    // Fixed priority falls to channel 1 once channel 0 drops.
    in_valid = 4'b1110;
    for (int i = 0; i < 2; i++) begin
      step("drop0");
      check_eq("drop0.fx_sel_const", 32'(fx_out_sel), 32'd1);
      check_eq("drop0.fx_data_const", 32'(fx_out_data), 32'h5);
    end

    // Backpressure: load channel 2, stall 3 cycles, then drain+reload.
    in_valid = 4'b0100;
    step("bp_fill");
    check_eq("bp_fill.rr_sel_const", 32'(rr_out_sel), 32'd2);
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("bp_hold");
      check_eq("bp_hold.rr_ready_const", 32'(rr_in_ready), 32'd0);
      check_eq("bp_hold.rr_data_const", 32'(rr_out_data), 32'h9);
    end
    out_ready = 1'b1;
    step("bp_release");
    check_eq("bp_release.rr_sel_const", 32'(rr_out_sel), 32'd3);
    check_eq("bp_release.rr_valid_const", 32'(rr_out_valid), 32'd1);

    // Pointer wrap with sparse requests, then idle drain.
    in_valid = 4'b0100;
    step("wrap_ptr3");
    in_valid = 4'b0101;
    step("wrap_g0");
    check_eq("wrap_g0.rr_sel_const", 32'(rr_out_sel), 32'd0);
    step("wrap_g2");
    check_eq("wrap_g2.rr_sel_const", 32'(rr_out_sel), 32'd2);
    in_valid = 4'b0000;
    step("idle1");
    step("idle2");
    check_eq("idle2.rr_valid_const", 32'(rr_out_valid), 32'd0);
    in_valid = 4'b1111;
    step("idle_ptr");
    check_eq("idle_ptr.rr_sel_const", 32'(rr_out_sel), 32'd3);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
      step("rand");
    end

    // Reset between edges while full.
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    step("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("mid_rst.rr_valid", 32'(rr_out_valid), 32'd0);
    check_eq("mid_rst.fx_valid", 32'(fx_out_valid), 32'd0);
    check_eq("mid_rst.rr_ready", 32'(rr_in_ready), 32'd0);
    @(posedge clk);
    #1;
    check_out("in_rst");
    rst_n = 1'b1;
    in_data = {4'hC, 4'h9, 4'h5, 4'h3};
    step("post_rst");
    check_eq("post_rst.rr_sel_const", 32'(rr_out_sel), 32'd0);
    step("post_rst2");
    check_eq("post_rst2.rr_sel_const", 32'(rr_out_sel), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_mux.md
# rr_mux

Parametrised N-channel, W-bit multiplexer that replaces the fixed 4:1 select-driven mux with arbitrated selection and a registered output stage. Each input channel is a valid/ready stream. The block picks one requesting channel per cycle by fixed priority or round-robin and forwards its word through a one-entry output register. It sits between several producers and a single consumer, for example lab datapaths that share one bus or display.

## Interface
- `NCH`, 4: number of input channels; must be ≥2.
- `WIDTH`, 4: data width per channel; must be ≥1.
- `MODE`, 1: arbitration mode. 0 selects fixed priority (lowest index wins). 1 selects round-robin.
- `SELW`, `$clog2(NCH)`: derived width of the channel index; not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  NCH  channel i holds a word.
- `in_ready`  out  NCH  channel i's word is accepted this cycle; one-hot or zero.
- `out_data`  out  WIDTH  registered data.
- `out_sel`  out  SELW  index of the channel that produced `out_data`.
- `out_valid`  out  1  the output register holds a word.
- `out_ready`  in  1  the consumer takes the word this cycle.

## Operation
- Output register state: EMPTY (`out_valid`=0) or FULL (`out_valid`=1).
- `can_load` = !out_valid || out_ready.
- The grant is combinational from `in_valid` and the priority pointer `ptr` (SELW bits):
  - MODE 0: the lowest set index of `in_valid`; `ptr` is ignored and held at 0.
  - MODE 1: the first set index at or after `ptr`, scanning upward and wrapping from NCH-1 to 0.
- `in_ready` = grant one-hot AND `can_load`. When no input is valid, `in_ready` is all zeros.
- Accept happens when `in_valid[g]` && `in_ready[g]`. On the next edge:
  - `out_data` loads channel g's word.
  - `out_sel` loads g.
  - `out_valid` goes to 1.
  - MODE 1 only: `ptr` loads (g+1) mod NCH, so the granted channel gets lowest priority next.
- Drain without a new accept (out_valid && out_ready): `out_valid` goes to 0. `out_data` and `out_sel` hold their last values.
- Simultaneous drain and accept in the same cycle: the register reloads and `out_valid` stays 1. Sustained throughput is one word per cycle.
- FULL with `out_ready`=0: `in_ready` is all zeros and the output holds stable (backpressure).
- No request: `ptr` does not move.
- Upstream must hold data stable while valid && !ready. The block is not required to tolerate violations.
- Reset asserted at any time, including mid-transfer, discards the held word with no partial output.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_sel`=0, `ptr`=0. `in_ready` evaluates to 0 during reset.
- Reset assertion takes effect immediately, without waiting for a clock edge. Release is synchronous to the next `clk` edge, and the first accept is possible on that edge.
- Latency: 1 cycle. A word accepted at edge k appears on `out_data`/`out_valid` after edge k.
- `in_ready` depends combinationally on `in_valid`, `out_valid` and `out_ready`. `out_*` are purely registered.
- Round-robin fairness: with all NCH channels continuously valid and `out_ready`=1, each channel is granted exactly once in every NCH consecutive accepts.

## Structure
- Package `rr_mux_pkg` holds:
  - `MODE_FIXED`=0 and `MODE_RR`=1 localparams.
  - A clog2-safe index-width helper function.
- Sub-module `rr_arbiter` (parameters NCH, MODE) contains the combinational grant logic. It takes `req`[NCH] and `ptr`, and produces grant one-hot, grant index and `any`.
- The top level `rr_mux` holds:
  - the output register and its FULL/EMPTY bit,
  - the `ptr` register,
  - the data select, implemented as an indexed part-select.

## Test plan
- Reset value: hold `rst_n`=0 with `in_valid`=4'b1111 → `out_valid`=0, `out_data`=0, `out_sel`=0, `in_ready`=0.
- Round-robin, NCH=4, WIDTH=4: data a=0x3, b=0x5, c=0x9, d=0xC, `in_valid`=4'b1111, `out_ready`=1 for 8 cycles.
  - Required `out_sel` sequence: 0,1,2,3,0,1,2,3.
  - Required `out_data` sequence: 0x3,0x5,0x9,0xC repeating.
  - `out_valid` stays high continuously.
- Fixed priority, MODE=0: same stimulus → `out_sel` is always 0 and `out_data` is always 0x3. Then drop `in_valid[0]` → `out_sel`=1 and `out_data`=0x5.
- Backpressure: fill the output register with `out_sel`=2 and data 0x9, then set `out_ready`=0 for 3 cycles.
  - `in_ready`=0 throughout and the output is stable.
  - Raising `out_ready` drains and reloads in the same cycle.
  - `ptr` advances only on accepts.
- Pointer wrap and sparse requests, MODE=1: with `ptr`=3 and `in_valid`=4'b0101 → grant 0, then `ptr`=1 → next grant 2. With `in_valid`=0 for 2 cycles → `out_valid` falls after the drain and `ptr` is unchanged.
- Reset mid-operation: assert `rst_n`=0 between edges while `out_valid`=1 → `out_valid` drops immediately, before the next edge, and `ptr` returns to 0. After release, the first grant is channel 0.
